// File: rtl/npu_pkg.sv
// npu_pkg: shared types and constants for the NPU PE array control path.
//   npu_seq_state_e : sequencer FSM states
//   npu_pe_mode_e   : PE mode encoding (shared with pe_core)
//   NPU_K_SIZE / NPU_KK / NPU_W_SEL_W / NPU_X_SEL_W : default kernel geometry and select widths
package npu_pkg;

  localparam int unsigned NPU_K_SIZE  = 3;
  localparam int unsigned NPU_KK      = NPU_K_SIZE * NPU_K_SIZE;
  localparam int unsigned NPU_W_SEL_W = (NPU_KK > 1) ? $clog2(NPU_KK) : 1;
  localparam int unsigned NPU_X_SEL_W = $clog2(2 * NPU_KK);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StMac,
    StDrain,
    StWait,
    StDone
  } npu_seq_state_e;

  typedef enum logic [1:0] {
    PeModeMac  = 2'd0,
    PeModeMax  = 2'd1,
    PeModeAdd  = 2'd2,
    PeModePass = 2'd3
  } npu_pe_mode_e;

endpackage

// File: rtl/npu_pe_sequencer_if.sv
// npu_pe_sequencer_if: control/status bundle between the host register block (master)
// and the PE sequencer (slave).
//   Host -> sequencer : start_i, abort_i, continue_i, bcast_i, passes_i, mode_i, lane_mask_i
//   Sequencer -> PE / host : pe_en_o, reg_reset_o, mode_sel_o, w_sel_o, x_sel_o,
//                            buf_lock_o, busy_o, wait_o, done_o, pass_cnt_o
interface npu_pe_sequencer_if #(
  parameter int unsigned N      = 10,
  parameter int unsigned K_SIZE = 3,
  parameter int unsigned PASS_W = 4,
  parameter int unsigned MODE_W = 2
);

  localparam int unsigned KK      = K_SIZE * K_SIZE;
  localparam int unsigned W_SEL_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int unsigned X_SEL_W = $clog2(2 * KK);

  logic              start_i;
  logic              abort_i;
  logic              continue_i;
  logic              bcast_i;
  logic [PASS_W-1:0] passes_i;
  logic [MODE_W-1:0] mode_i;
  logic [N-1:0]      lane_mask_i;

  logic [N-1:0]       pe_en_o;
  logic               reg_reset_o;
  logic [MODE_W-1:0]  mode_sel_o;
  logic [W_SEL_W-1:0] w_sel_o;
  logic [X_SEL_W-1:0] x_sel_o;
  logic               buf_lock_o;
  logic               busy_o;
  logic               wait_o;
  logic               done_o;
  logic [PASS_W-1:0]  pass_cnt_o;

  modport master (
    output start_i, abort_i, continue_i, bcast_i, passes_i, mode_i, lane_mask_i,
    input  pe_en_o, reg_reset_o, mode_sel_o, w_sel_o, x_sel_o, buf_lock_o, busy_o,
           wait_o, done_o, pass_cnt_o
  );

  modport slave (
    input  start_i, abort_i, continue_i, bcast_i, passes_i, mode_i, lane_mask_i,
    output pe_en_o, reg_reset_o, mode_sel_o, w_sel_o, x_sel_o, buf_lock_o, busy_o,
           wait_o, done_o, pass_cnt_o
  );

endinterface

// File: rtl/npu_step_counter.sv
// npu_step_counter: loadable down-counter with terminal flag.
//   clk, reset  : clock, async active-low reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_en        : decrement by one, saturating at zero
//   o_count     : current count
//   o_term      : count is zero
module npu_step_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_en,
  output logic [Width-1:0] o_count,
  output logic             o_term
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == '0);

endmodule

// File: rtl/npu_pe_sequencer.sv
// npu_pe_sequencer: control sequencer for the NPU PE array.
// A job clears the accumulators, steps the weight/input muxes through all KK kernel taps,
// drains the PE pipeline for PE_LAT cycles and either waits for the host to reload the
// operand buffer (more passes to go) or pulses done.
//   clk, reset : clock, async active-low reset
//   bus        : npu_pe_sequencer_if.slave (host commands/config in, PE controls/status out)
// All outputs are decoded from registered state only.
module npu_pe_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned N      = 10,
  parameter int unsigned K_SIZE = NPU_K_SIZE,
  parameter int unsigned PE_LAT = 2,
  parameter int unsigned PASS_W = 4,
  parameter int unsigned MODE_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  npu_pe_sequencer_if.slave bus
);

  localparam int unsigned KK      = K_SIZE * K_SIZE;
  localparam int unsigned W_SEL_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int unsigned X_SEL_W = $clog2(2 * KK);
  localparam int unsigned DRN_W   = $clog2(PE_LAT + 1);

  npu_seq_state_e    r_state, w_state_next;
  logic              r_bcast;
  logic [PASS_W-1:0] r_passes;
  logic [MODE_W-1:0] r_mode;
  logic [N-1:0]      r_mask;
  logic [PASS_W-1:0] r_pass_cnt;
  logic              r_abort_clr;

  logic               w_start_ok;
  logic               w_abort_ok;
  logic               w_tap_load, w_tap_en, w_tap_term;
  logic               w_drn_load, w_drn_en, w_drn_term;
  logic               w_pass_inc;
  logic               w_pass_last;
  logic [W_SEL_W-1:0] w_tap_cnt;
  logic [W_SEL_W-1:0] w_tap;
  logic [X_SEL_W-1:0] w_tap_x;
  logic [DRN_W-1:0]   w_drn_cnt_unused;

  assign w_start_ok = (r_state == StIdle) && bus.start_i;
  assign w_abort_ok = (r_state != StIdle) && bus.abort_i;

  // passes_i == 0 runs a single pass
  assign w_pass_last = (r_passes == '0) ? (r_pass_cnt == '0)
                                        : (r_pass_cnt == (r_passes - PASS_W'(1)));

  npu_step_counter #(
    .Width (W_SEL_W)
  ) u_tap_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_tap_load),
    .i_load_val (W_SEL_W'(KK - 1)),
    .i_en       (w_tap_en),
    .o_count    (w_tap_cnt),
    .o_term     (w_tap_term)
  );

  npu_step_counter #(
    .Width (DRN_W)
  ) u_drn_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_drn_load),
    .i_load_val (DRN_W'(PE_LAT - 1)),
    .i_en       (w_drn_en),
    .o_count    (w_drn_cnt_unused),
    .o_term     (w_drn_term)
  );

  // The tap counter runs down, so the tap index is its complement against KK-1.
  assign w_tap   = W_SEL_W'(KK - 1) - w_tap_cnt;
  assign w_tap_x = X_SEL_W'(w_tap);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tap_load   = 1'b0;
    w_tap_en     = 1'b0;
    w_drn_load   = 1'b0;
    w_drn_en     = 1'b0;
    w_pass_inc   = 1'b0;
    if (w_abort_ok) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start_i) w_state_next = StClear;
        end
        StClear: begin
          w_state_next = StMac;
          w_tap_load   = 1'b1;
        end
        StMac: begin
          w_tap_en = 1'b1;
          if (w_tap_term) begin
            w_state_next = StDrain;
            w_drn_load   = 1'b1;
          end
        end
        StDrain: begin
          w_drn_en = 1'b1;
          if (w_drn_term) begin
            if (w_pass_last) begin
              w_state_next = StDone;
            end else begin
              w_pass_inc   = 1'b1;
              w_state_next = StWait;
            end
          end
        end
        StWait: begin
          // no CLEAR on the way back, so passes accumulate
          if (bus.continue_i) begin
            w_state_next = StMac;
            w_tap_load   = 1'b1;
          end
        end
        StDone: begin
          w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // Job config, pass index and abort-clear flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcast     <= 1'b0;
      r_passes    <= '0;
      r_mode      <= '0;
      r_mask      <= '0;
      r_pass_cnt  <= '0;
      r_abort_clr <= 1'b0;
    end else begin
      r_abort_clr <= w_abort_ok;
      if (w_start_ok) begin
        r_bcast    <= bus.bcast_i;
        r_passes   <= bus.passes_i;
        r_mode     <= bus.mode_i;
        r_mask     <= bus.lane_mask_i;
        r_pass_cnt <= '0;
      end else if (w_pass_inc && !w_abort_ok) begin
        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
      end
    end
  end

  always_comb begin
    bus.pe_en_o     = '0;
    bus.w_sel_o     = '0;
    bus.x_sel_o     = '0;
    if (r_state == StMac) begin
      bus.pe_en_o = r_mask;
      bus.w_sel_o = w_tap;
      // mux order {direct, broadcast}: broadcast taps at 0..KK-1, direct at KK..2KK-1
      bus.x_sel_o = r_bcast ? w_tap_x : (w_tap_x + X_SEL_W'(KK));
    end
    bus.reg_reset_o = (r_state == StClear) || r_abort_clr;
    bus.buf_lock_o  = (r_state == StClear) || (r_state == StMac) || (r_state == StDrain);
    bus.busy_o      = (r_state != StIdle);
    bus.wait_o      = (r_state == StWait);
    bus.done_o      = (r_state == StDone);
    bus.mode_sel_o  = (r_state != StIdle) ? r_mode : '0;
    bus.pass_cnt_o  = r_pass_cnt;
  end

endmodule

// File: tb/tb_npu_pe_sequencer.sv
// tb_npu_pe_sequencer: directed self-checking bench for npu_pe_sequencer.
// Inputs change 1 ns after the rising edge and outputs are checked at the same point,
// so each tick() advances exactly one cycle of the sequencer.
module tb_npu_pe_sequencer;
  import npu_pkg::*;

  localparam int unsigned N      = 10;
  localparam int unsigned K_SIZE = 3;
  localparam int unsigned PE_LAT = 2;
  localparam int unsigned PASS_W = 4;
  localparam int unsigned MODE_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  npu_pe_sequencer_if #(
    .N      (N),
    .K_SIZE (K_SIZE),
    .PASS_W (PASS_W),
    .MODE_W (MODE_W)
  ) bus ();

  npu_pe_sequencer #(
    .N      (N),
    .K_SIZE (K_SIZE),
    .PE_LAT (PE_LAT),
    .PASS_W (PASS_W),
    .MODE_W (MODE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters sampled mid-cycle on the falling edge.
  int   n_done = 0;
  int   n_rr   = 0;
  int   n_wr   = 0;
  logic r_wait_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.done_o === 1'b1) n_done <= n_done + 1;
    if (bus.reg_reset_o === 1'b1) n_rr <= n_rr + 1;
    if ((bus.wait_o === 1'b1) && !r_wait_prev) n_wr <= n_wr + 1;
    r_wait_prev <= (bus.wait_o === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start_i    = 1'b0;
    bus.continue_i = 1'b0;
    bus.abort_i    = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pe_en"}, 32'(bus.pe_en_o), 0);
    chk({tag, "_rr"}, 32'(bus.reg_reset_o), 0);
    chk({tag, "_mode"}, 32'(bus.mode_sel_o), 0);
    chk({tag, "_wsel"}, 32'(bus.w_sel_o), 0);
    chk({tag, "_xsel"}, 32'(bus.x_sel_o), 0);
    chk({tag, "_lock"}, 32'(bus.buf_lock_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_wait"}, 32'(bus.wait_o), 0);
    chk({tag, "_done"}, 32'(bus.done_o), 0);
    chk({tag, "_pcnt"}, 32'(bus.pass_cnt_o), 0);
  endtask

  // Issue start from IDLE; returns in the CLEAR cycle. Inputs are scrambled afterwards
  // so a config that is not latched shows up in later checks.
  task automatic start_job(input logic bcast, input logic [PASS_W-1:0] passes,
                           input logic [MODE_W-1:0] mode, input logic [N-1:0] mask);
    bus.bcast_i     = bcast;
    bus.passes_i    = passes;
    bus.mode_i      = mode;
    bus.lane_mask_i = mask;
    bus.start_i     = 1'b1;
    tick();
    bus.bcast_i     = ~bcast;
    bus.passes_i    = ~passes;
    bus.mode_i      = ~mode;
    bus.lane_mask_i = ~mask;
    chk("clr_rr", 32'(bus.reg_reset_o), 1);
    chk("clr_lock", 32'(bus.buf_lock_o), 1);
    chk("clr_busy", 32'(bus.busy_o), 1);
    chk("clr_pe_en", 32'(bus.pe_en_o), 0);
    chk("clr_mode", 32'(bus.mode_sel_o), 32'(mode));
  endtask

  // Step ntaps MAC cycles; optionally pulse start+continue at tap 3 (both must be ignored).
  task automatic run_mac(input logic [N-1:0] mask, input logic bcast,
                         input logic [PASS_W-1:0] pcnt, input bit inject, input int ntaps);
    for (int i = 0; i < ntaps; i++) begin
      tick();
      chk("mac_wsel", 32'(bus.w_sel_o), 32'(i));
      chk("mac_xsel", 32'(bus.x_sel_o), bcast ? 32'(i) : 32'(i + 9));
      chk("mac_pe_en", 32'(bus.pe_en_o), 32'(mask));
      chk("mac_lock", 32'(bus.buf_lock_o), 1);
      chk("mac_rr", 32'(bus.reg_reset_o), 0);
      chk("mac_pcnt", 32'(bus.pass_cnt_o), 32'(pcnt));
      if (inject && (i == 3)) begin
        bus.start_i    = 1'b1;
        bus.continue_i = 1'b1;
      end
    end
  endtask

  task automatic run_drain();
    for (int i = 0; i < PE_LAT; i++) begin
      tick();
      chk("drn_pe_en", 32'(bus.pe_en_o), 0);
      chk("drn_wsel", 32'(bus.w_sel_o), 0);
      chk("drn_xsel", 32'(bus.x_sel_o), 0);
      chk("drn_lock", 32'(bus.buf_lock_o), 1);
      chk("drn_busy", 32'(bus.busy_o), 1);
      chk("drn_done", 32'(bus.done_o), 0);
      chk("drn_wait", 32'(bus.wait_o), 0);
    end
  endtask

  int d0, rr0, w0;

  initial begin
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.continue_i  = 1'b0;
    bus.bcast_i     = 1'b0;
    bus.passes_i    = '0;
    bus.mode_i      = '0;
    bus.lane_mask_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    tick();
    chk_zero("idle");

    // Single pass, direct, full mask; start/continue during MAC must not disturb it
    d0 = n_done;
    start_job(1'b0, 4'd1, PeModeAdd, 10'h3FF);
    run_mac(10'h3FF, 1'b0, 4'd0, 1'b1, 9);
    run_drain();
    tick();
    chk("sp_done", 32'(bus.done_o), 1);
    chk("sp_done_mode", 32'(bus.mode_sel_o), 2);
    chk("sp_done_lock", 32'(bus.buf_lock_o), 0);
    tick();
    chk("sp_idle_busy", 32'(bus.busy_o), 0);
    chk("sp_idle_done", 32'(bus.done_o), 0);
    chk("sp_idle_mode", 32'(bus.mode_sel_o), 0);
    chk("sp_ndone", 32'(n_done - d0), 1);

    // Broadcast, mask 0x005, started in the cycle after DONE
    start_job(1'b1, 4'd1, PeModeMax, 10'h005);
    run_mac(10'h005, 1'b1, 4'd0, 1'b0, 9);
    run_drain();
    tick();
    chk("bc_done", 32'(bus.done_o), 1);
    tick();
    chk("bc_idle_busy", 32'(bus.busy_o), 0);
    chk("bc_idle_pe_en", 32'(bus.pe_en_o), 0);

    // Three passes with a delayed continue
    d0  = n_done;
    rr0 = n_rr;
    w0  = n_wr;
    start_job(1'b0, 4'd3, PeModePass, 10'h155);
    run_mac(10'h155, 1'b0, 4'd0, 1'b0, 9);
    run_drain();
    tick();
    chk("mp_wait1", 32'(bus.wait_o), 1);
    chk("mp_wait1_lock", 32'(bus.buf_lock_o), 0);
    chk("mp_wait1_pcnt", 32'(bus.pass_cnt_o), 1);
    chk("mp_wait1_busy", 32'(bus.busy_o), 1);
    chk("mp_wait1_mode", 32'(bus.mode_sel_o), 3);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("mp_hold_wait", 32'(bus.wait_o), 1);
      chk("mp_hold_pe_en", 32'(bus.pe_en_o), 0);
    end
    bus.continue_i = 1'b1;
    run_mac(10'h155, 1'b0, 4'd1, 1'b0, 9);
    run_drain();
    tick();
    chk("mp_wait2", 32'(bus.wait_o), 1);
    chk("mp_wait2_pcnt", 32'(bus.pass_cnt_o), 2);
    bus.continue_i = 1'b1;
    run_mac(10'h155, 1'b0, 4'd2, 1'b0, 9);
    run_drain();
    tick();
    chk("mp_done", 32'(bus.done_o), 1);
    chk("mp_done_wait", 32'(bus.wait_o), 0);
    chk("mp_done_pcnt", 32'(bus.pass_cnt_o), 2);
    tick();
    chk("mp_idle_busy", 32'(bus.busy_o), 0);
    chk("mp_nrr", 32'(n_rr - rr0), 1);
    chk("mp_ndone", 32'(n_done - d0), 1);
    chk("mp_nwait", 32'(n_wr - w0), 2);

    // passes_i = 0 behaves as a single pass
    d0 = n_done;
    w0 = n_wr;
    start_job(1'b0, 4'd0, PeModeMac, 10'h3FF);
    run_mac(10'h3FF, 1'b0, 4'd0, 1'b0, 9);
    run_drain();
    tick();
    chk("p0_done", 32'(bus.done_o), 1);
    chk("p0_wait", 32'(bus.wait_o), 0);
    tick();
    chk("p0_idle_busy", 32'(bus.busy_o), 0);
    chk("p0_nwait", 32'(n_wr - w0), 0);
    chk("p0_ndone", 32'(n_done - d0), 1);

    // Abort at MAC tap 4 (with a simultaneous start), then abort in IDLE, then a normal job
    d0 = n_done;
    start_job(1'b0, 4'd1, PeModeMax, 10'h3FF);
    run_mac(10'h3FF, 1'b0, 4'd0, 1'b0, 5);
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    chk("ab_busy", 32'(bus.busy_o), 0);
    chk("ab_rr", 32'(bus.reg_reset_o), 1);
    chk("ab_pe_en", 32'(bus.pe_en_o), 0);
    chk("ab_lock", 32'(bus.buf_lock_o), 0);
    chk("ab_mode", 32'(bus.mode_sel_o), 0);
    chk("ab_done", 32'(bus.done_o), 0);
    tick();
    chk("ab_post_rr", 32'(bus.reg_reset_o), 0);
    chk("ab_post_busy", 32'(bus.busy_o), 0);
    bus.abort_i = 1'b1;
    tick();
    chk("ab_idle_rr", 32'(bus.reg_reset_o), 0);
    chk("ab_idle_busy", 32'(bus.busy_o), 0);
    chk("ab_ndone", 32'(n_done - d0), 0);
    start_job(1'b1, 4'd1, PeModeMac, 10'h2AA);
    run_mac(10'h2AA, 1'b1, 4'd0, 1'b0, 9);
    run_drain();
    tick();
    chk("ab_rerun_done", 32'(bus.done_o), 1);
    tick();

    // Asynchronous reset mid-DRAIN
    start_job(1'b0, 4'd2, PeModeAdd, 10'h3FF);
    run_mac(10'h3FF, 1'b0, 4'd0, 1'b0, 9);
    tick();
    chk("rd_lock", 32'(bus.buf_lock_o), 1);
    reset = 1'b0;
    #1;
    chk_zero("rst_async");
    tick();
    reset = 1'b1;
    tick();
    chk_zero("rst_after");

    // Normal job after reset
    start_job(1'b0, 4'd1, PeModeMac, 10'h0F0);
    run_mac(10'h0F0, 1'b0, 4'd0, 1'b0, 9);
    run_drain();
    tick();
    chk("fin_done", 32'(bus.done_o), 1);
    tick();
    chk("fin_busy", 32'(bus.busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
